// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    HELD
  } state_t;

  // Index of the lowest-numbered row pulled low; only meaningful when some row is low.
  function automatic logic [1:0] lowest_low(input logic [KEY_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = KEY_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column drive, synchronized row sense,
// debounced press/release and a one-cycle key event with its code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE   = 4,
  parameter int DEBOUNCE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [KEY_COLS-1:0]   key_col,
  input  logic [KEY_ROWS-1:0]   key_row,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_held
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE - 1);

  state_t                  state, state_next;
  logic [1:0]              col_idx, col_next;
  logic [SW-1:0]           settle_cnt, settle_next;
  logic [DW-1:0]           deb_cnt, deb_next;
  logic [1:0]              cand_row, cand_next;
  logic                    valid_next, held_next;
  logic [KEY_CODE_W-1:0]   code_next;
  logic [KEY_ROWS-1:0]     row_s;
  logic                    cand_bit;

  sync_2ff #(
    .WIDTH       (KEY_ROWS),
    .RESET_VALUE (4'b1111)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (key_row),
    .q     (row_s)
  );

  assign key_col  = ~(4'b0001 << col_idx);
  assign cand_bit = row_s[cand_row];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SCAN;
      col_idx    <= 2'd0;
      settle_cnt <= '0;
      deb_cnt    <= '0;
      cand_row   <= 2'd0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_held   <= 1'b0;
    end else begin
      state      <= state_next;
      col_idx    <= col_next;
      settle_cnt <= settle_next;
      deb_cnt    <= deb_next;
      cand_row   <= cand_next;
      key_valid  <= valid_next;
      key_code   <= code_next;
      key_held   <= held_next;
    end
  end

  // The column stays frozen from detection until the candidate is rejected or released.
  always_comb begin
    state_next  = state;
    col_next    = col_idx;
    settle_next = settle_cnt;
    deb_next    = deb_cnt;
    cand_next   = cand_row;
    valid_next  = 1'b0;
    code_next   = key_code;
    held_next   = key_held;

    case (state)
      SCAN: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_next = '0;
          if (row_s == '1) begin
            col_next = col_idx + 2'd1;
          end else begin
            cand_next  = lowest_low(row_s);
            state_next = CONFIRM;
          end
        end else begin
          settle_next = settle_cnt + 1'b1;
        end
      end

      CONFIRM: begin
        if (cand_bit) begin
          deb_next    = '0;
          state_next  = SCAN;
          col_next    = col_idx + 2'd1;
          settle_next = '0;
        end else if (deb_cnt == DEB_LAST) begin
          valid_next = 1'b1;
          code_next  = {cand_row, col_idx};
          held_next  = 1'b1;
          state_next = HELD;
          deb_next   = '0;
        end else begin
          deb_next = deb_cnt + 1'b1;
        end
      end

      HELD: begin
        if (!cand_bit) begin
          deb_next = '0;
        end else if (deb_cnt == DEB_LAST) begin
          held_next   = 1'b0;
          state_next  = SCAN;
          col_next    = col_idx + 2'd1;
          settle_next = '0;
          deb_next    = '0;
        end else begin
          deb_next = deb_cnt + 1'b1;
        end
      end

      default: state_next = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner; a small key-matrix model turns pressed keys
// into row levels for whichever column is currently driven.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [15:0] pressed;

  int tests_run    = 0;
  int tests_failed = 0;

  keypad_scanner #(
    .SETTLE   (4),
    .DEBOUNCE (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_col   (key_col),
    .key_row   (key_row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rows_for(input logic [15:0] p, input logic [3:0] col);
    logic [3:0] r;
    r = 4'b1111;
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && p[row*4+c]) r[row] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] col_drive(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (idx % 4));
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    key_row = rows_for(pressed, key_col);
  endtask

  task automatic applyStimulus(input logic [15:0] p);
    pressed = p;
    key_row = rows_for(pressed, key_col);
  endtask

  // Returns just after the edge on which key_col newly switches to target.
  task automatic wait_col_entry(input logic [3:0] target);
    int n;
    n = 0;
    while (key_col == target && n < 64) begin
      tick();
      n++;
    end
    while (key_col != target && n < 64) begin
      tick();
      n++;
    end
    checkOutput("col_entry_timeout", (n < 64) ? 8'd1 : 8'd0, 8'd1);
  endtask

  initial begin
    reset   = 1'b1;
    pressed = '0;
    key_row = 4'b1111;
    #1 reset = 1'b0;
    tick();
    tick();
    checkOutput("reset_col",   key_col,   4'b1110);
    checkOutput("reset_valid", key_valid, 1'b0);
    checkOutput("reset_code",  key_code,  4'h0);
    checkOutput("reset_held",  key_held,  1'b0);
    reset = 1'b1;

    for (int k = 1; k <= 64; k++) begin
      tick();
      checkOutput("idle_col",   key_col,   col_drive(k / 4));
      checkOutput("idle_valid", key_valid, 1'b0);
      checkOutput("idle_held",  key_held,  1'b0);
    end

    // Stable press of row 2 / col 2, detected at i=4, event after i=12.
    wait_col_entry(4'b1011);
    applyStimulus(16'h0400);
    for (int i = 1; i <= 20; i++) begin
      tick();
      checkOutput("press_valid", key_valid, (i == 12) ? 1'b1 : 1'b0);
      checkOutput("press_code",  key_code,  (i >= 12) ? 4'hA : 4'h0);
      checkOutput("press_held",  key_held,  (i >= 12) ? 1'b1 : 1'b0);
      checkOutput("press_col",   key_col,   4'b1011);
    end

    // Five-cycle release glitch must not end the hold or re-trigger.
    applyStimulus(16'h0000);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput("glitch_held",  key_held,  1'b1);
      checkOutput("glitch_valid", key_valid, 1'b0);
    end
    applyStimulus(16'h0400);
    for (int i = 1; i <= 15; i++) begin
      tick();
      checkOutput("repress_held",  key_held,  1'b1);
      checkOutput("repress_valid", key_valid, 1'b0);
    end

    // Real release: synchronized at i=2, hold drops and column advances at i=10.
    applyStimulus(16'h0000);
    for (int i = 1; i <= 12; i++) begin
      tick();
      checkOutput("release_held",  key_held,  (i < 10) ? 1'b1 : 1'b0);
      checkOutput("release_col",   key_col,   (i < 10) ? 4'b1011 : 4'b0111);
      checkOutput("release_valid", key_valid, 1'b0);
    end

    // Row 1 / col 0 bouncing every 3 cycles never confirms.
    wait_col_entry(4'b1110);
    for (int i = 0; i < 40; i++) begin
      applyStimulus((((i / 3) % 2) == 0) ? 16'h0010 : 16'h0000);
      tick();
      checkOutput("bounce_valid", key_valid, 1'b0);
      checkOutput("bounce_held",  key_held,  1'b0);
    end
    applyStimulus(16'h0000);
    wait_col_entry(4'b1110);
    applyStimulus(16'h0010);
    for (int i = 1; i <= 14; i++) begin
      tick();
      checkOutput("settled_valid", key_valid, (i == 12) ? 1'b1 : 1'b0);
      checkOutput("settled_code",  key_code,  (i >= 12) ? 4'h4 : 4'hA);
      checkOutput("settled_held",  key_held,  (i >= 12) ? 1'b1 : 1'b0);
      checkOutput("settled_col",   key_col,   4'b1110);
    end
    applyStimulus(16'h0000);
    for (int i = 1; i <= 12; i++) tick();
    checkOutput("settled_release_held", key_held, 1'b0);

    // Rows 0 and 3 on col 1: lowest row wins, then row 3 is picked up on the next pass.
    wait_col_entry(4'b1101);
    applyStimulus(16'h2002);
    for (int i = 1; i <= 14; i++) begin
      tick();
      checkOutput("dual_valid", key_valid, (i == 12) ? 1'b1 : 1'b0);
      checkOutput("dual_code",  key_code,  (i >= 12) ? 4'h1 : 4'h4);
      checkOutput("dual_held",  key_held,  (i >= 12) ? 1'b1 : 1'b0);
    end
    applyStimulus(16'h2000);
    for (int i = 1; i <= 36; i++) begin
      tick();
      checkOutput("second_valid", key_valid, (i == 34) ? 1'b1 : 1'b0);
      checkOutput("second_held",  key_held,  (i < 10 || i >= 34) ? 1'b1 : 1'b0);
      checkOutput("second_code",  key_code,  (i >= 34) ? 4'hD : 4'h1);
      checkOutput("second_col",   key_col,
                  (i < 10 || i >= 22) ? 4'b1101 : col_drive((i - 10) / 4 + 2));
    end
    applyStimulus(16'h0000);
    for (int i = 1; i <= 12; i++) tick();
    checkOutput("second_release_held", key_held, 1'b0);

    // Reset in the middle of CONFIRM on row 0 / col 3.
    wait_col_entry(4'b0111);
    applyStimulus(16'h0008);
    for (int i = 1; i <= 6; i++) tick();
    checkOutput("confirm_col",   key_col,   4'b0111);
    checkOutput("confirm_valid", key_valid, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("midreset_col",   key_col,   4'b1110);
    checkOutput("midreset_valid", key_valid, 1'b0);
    checkOutput("midreset_held",  key_held,  1'b0);
    checkOutput("midreset_code",  key_code,  4'h0);
    applyStimulus(16'h0000);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("inreset_valid", key_valid, 1'b0);
      checkOutput("inreset_col",   key_col,   4'b1110);
    end
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput("restart_col",   key_col,   col_drive(k / 4));
      checkOutput("restart_valid", key_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low key matrix for the Pong game's paddle and control input. It drives one column low at a time and samples the row lines through a synchronizer, then debounces the press and emits a one-cycle key event with a 4-bit code. It is the input-side counterpart of the LED dot-matrix row scanner and runs on the same `clk`/`reset`.

## Interface
- `SETTLE`, default 4: cycles each column is driven before its rows are sampled. Legal range ≥3, covering the 2-flop synchronizer plus 1.
- `DEBOUNCE`, default 8: consecutive identical samples required to accept a press or a release. Legal range ≥2.
- `clk` input 1: system clock.
- `reset` input 1: reset, asynchronous, active-low.
- `key_col` output 4: column drive, active-low, exactly one bit low at all times.
- `key_row` input 4: row sense, active-low, externally pulled up, asynchronous to `clk`.
- `key_valid` output 1: one-cycle pulse when a debounced press is accepted.
- `key_code` output 4: code of the last accepted key, `row*4 + col`, held until the next accepted press.
- `key_held` output 1: high from the `key_valid` cycle until the debounced release.

## Operation
- **Synchronizer:** `key_row` passes through a 2-flop synchronizer to give `row_s`. Synchronizer flops reset to `4'b1111`.
- **Column drive:** `key_col = ~(4'b0001 << col_idx)`. `col_idx` advances 0→1→2→3→0 and wraps.
- **States:** SCAN, CONFIRM, HELD. Reset state is SCAN.
- **SCAN:**
  - `settle_cnt` counts 0..SETTLE-1.
  - On `settle_cnt == SETTLE-1`, `row_s` is sampled.
  - If `row_s == 4'b1111`: `col_idx` increments, `settle_cnt` clears, state stays SCAN.
  - Otherwise: the candidate row is the lowest-index low bit of `row_s`, the candidate is latched as (row, `col_idx`), and the next state is CONFIRM. `col_idx` is frozen.
- **CONFIRM:**
  - Each cycle where `row_s[cand_row]` is low, `deb_cnt` increments.
  - When `deb_cnt == DEBOUNCE-1` and the bit is still low: next cycle `key_valid=1`, `key_code={cand_row,col_idx}`, `key_held=1`, state goes to HELD, `deb_cnt` clears.
  - If the bit is high in any CONFIRM cycle: `deb_cnt` clears, state goes to SCAN, `col_idx` increments, `settle_cnt` clears. No event is emitted.
- **HELD:**
  - `key_valid` deasserts after its single cycle.
  - Each cycle where `row_s[cand_row]` is high, `deb_cnt` increments. A low cycle clears `deb_cnt`.
  - When `deb_cnt == DEBOUNCE-1` and the bit is high: `key_held=0`, state goes to SCAN, `col_idx` increments, `settle_cnt` clears, `deb_cnt` clears.
- **Multiple keys:** only the candidate key is tracked. Other keys pressed during CONFIRM or HELD are ignored until release. Ghosting and rollover are not handled.
- **Counter widths:** `settle_cnt` is `$clog2(SETTLE)` bits and `deb_cnt` is `$clog2(DEBOUNCE)` bits. No overflow past the terminal value.
- **Reset mid-operation:** asynchronous return to SCAN. Any pending press is discarded and no `key_valid` is produced.

## Timing
- **Reset values:**
  - `key_col = 4'b1110`
  - `key_valid = 0`
  - `key_code = 4'h0`
  - `key_held = 0`
  - `col_idx = 0`, `settle_cnt = 0`, `deb_cnt = 0`, state SCAN
- **Scan period:** an idle full scan takes `4*SETTLE` cycles, which is 16 at defaults.
- **Press latency:** let D be the SCAN sample edge that detects the press. `key_valid` is high in the cycle after edge D+DEBOUNCE, for a stable press.
- **Release latency:** let R be the first edge at which `row_s` shows the release. `key_held` falls DEBOUNCE edges after R, and the column advance happens at that same edge.
- **`key_valid`:** always exactly 1 cycle wide, and never high outside the CONFIRM→HELD transition.
- **Drive-change rule:** `key_col` changes only on the edge where `settle_cnt` clears or `col_idx` increments. Rows are never sampled in the first SETTLE-1 cycles after a change.

## Structure
- **Shared package `keypad_pkg`:**
  - state enum `{SCAN, CONFIRM, HELD}`
  - `KEY_ROWS=4`, `KEY_COLS=4`
  - `KEY_CODE_W=4`
- **Sub-module `sync_2ff`:** a parameterized-width 2-flop synchronizer with asynchronous active-low reset and a reset value parameter, instantiated for `key_row`.

## Test plan
- **Idle scan:** hold `key_row=4'b1111` after reset for 64 cycles → `key_col` cycles 1110, 1101, 1011, 0111, each for 4 cycles; `key_valid` never asserts; `key_held=0`.
- **Stable press:** pull row 2 low while `key_col=4'b1011` (col 2) and keep it low → exactly one `key_valid` pulse; `key_code=4'hA`; `key_held=1` until release; `key_held` falls 8 cycles after synchronized release.
- **Bounce:** pull row 1/col 0 low and toggle it every 3 cycles for 40 cycles → no `key_valid`; scanning continues. Then hold it stable → one `key_valid` with `key_code=4'h4`.
- **Simultaneous keys:** pull rows 0 and 3 low on col 1 together → `key_code=4'h1`. Releasing row 0 while row 3 stays low → `key_held` falls. The next scan of col 1 then yields `key_code=4'hD`.
- **Reset mid-confirm:** assert `reset` during CONFIRM → outputs immediately take reset values; no `key_valid`; after deassert, scanning restarts at col 0.
- **Release glitch:** in HELD, release for 5 cycles then press again → `key_held` stays 1 and no second `key_valid`.
